// File: rtl/x_uart_dump_if.sv
// rtl/x_uart_dump_if.sv - UART pins and status flags of the delay-line dumper
interface x_uart_dump_if;
   logic i_uart_rx;
   logic o_uart_tx;
   logic o_busy;
   logic o_capture;

   modport slave  (input i_uart_rx, output o_uart_tx, o_busy, o_capture);
   modport master (output i_uart_rx, input o_uart_tx, o_busy, o_capture);
endinterface

// File: rtl/x_uart_dump.sv
// rtl/x_uart_dump.sv - 8N1 command receiver that snapshots a delay-line channel and streams it out
module x_uart_dump #(
   parameter int p_length   = 32,
   parameter int p_channels = 2,
   parameter int p_clk_hz   = 12000000,
   parameter int p_baud     = 115200
) (
   input  logic                           i_clk,
   input  logic                           i_nrst,
   input  logic [p_channels*p_length-1:0] i_data,
   x_uart_dump_if.slave                   uart
);
   localparam int p_timer_top = p_clk_hz / p_baud;
   localparam int c_tw        = $clog2(p_timer_top);
   localparam int c_nbytes    = (p_length + 7) / 8;
   localparam int c_padw      = c_nbytes * 8;
   localparam int c_bw        = ($clog2(c_nbytes + 1) < 1) ? 1 : $clog2(c_nbytes + 1);

   localparam logic [c_tw-1:0] c_top_m1  = c_tw'(p_timer_top - 1);
   localparam logic [c_tw-1:0] c_half_m1 = c_tw'(p_timer_top / 2 - 1);
   localparam logic [c_bw-1:0] c_last    = c_bw'(c_nbytes - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_e;
   typedef enum logic [3:0] {T_IDLE, T_START, T_D0, T_D1, T_D2, T_D3,
                             T_D4, T_D5, T_D6, T_D7, T_STOP} t_state_e;

   logic                rx_meta_q, rxs_q;
   r_state_e            r_state_q, r_state_d;
   logic [c_tw-1:0]     r_timer_q, r_timer_d;
   logic [2:0]          r_bit_q, r_bit_d;
   logic [7:0]          r_shift_q, r_shift_d;
   logic                rx_valid;

   t_state_e            t_state_q, t_state_d;
   logic [c_tw-1:0]     t_timer_q, t_timer_d;
   logic [c_bw-1:0]     byte_q, byte_d;
   logic [p_length-1:0] snap_q, snap_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                cap_q, cap_d;
   logic                tx_q, tx_d;

   logic [p_length-1:0] chan_word;
   logic [c_padw-1:0]   snap_pad;
   logic [7:0]          cur_byte;
   logic [2:0]          d_idx;
   logic                is_data, accept, last_byte;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         r_state_q <= R_IDLE;
         r_timer_q <= '0;
         r_bit_q   <= '0;
         r_shift_q <= '0;
         t_state_q <= T_IDLE;
         t_timer_q <= '0;
         byte_q    <= '0;
         snap_q    <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cap_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         rx_meta_q <= uart.i_uart_rx;
         rxs_q     <= rx_meta_q;
         r_state_q <= r_state_d;
         r_timer_q <= r_timer_d;
         r_bit_q   <= r_bit_d;
         r_shift_q <= r_shift_d;
         t_state_q <= t_state_d;
         t_timer_q <= t_timer_d;
         byte_q    <= byte_d;
         snap_q    <= snap_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         cap_q     <= cap_d;
         tx_q      <= tx_d;
      end
   end

   // Receiver: start bit confirmed at half a bit, then every sample lands mid-bit
   always_comb begin
      r_state_d = r_state_q;
      r_timer_d = r_timer_q + 1'b1;
      r_bit_d   = r_bit_q;
      r_shift_d = r_shift_q;
      rx_valid  = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            r_timer_d = '0;
            if (!rxs_q) r_state_d = R_START;
         end
         R_START: begin
            if (r_timer_q == c_half_m1) begin
               r_timer_d = '0;
               r_bit_d   = '0;
               r_state_d = rxs_q ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (r_timer_q == c_top_m1) begin
               r_timer_d = '0;
               r_shift_d = {rxs_q, r_shift_q[7:1]};
               r_bit_d   = r_bit_q + 1'b1;
               if (r_bit_q == 3'd7) r_state_d = R_STOP;
            end
         end
         R_STOP: begin
            if (r_timer_q == c_top_m1) begin
               r_timer_d = '0;
               rx_valid  = rxs_q;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      chan_word = '0;
      for (int c = 0; c < p_channels; c++) begin
         if (r_shift_q == 8'(c)) chan_word = i_data[c*p_length +: p_length];
      end
   end

   assign is_data = (32'(r_shift_q) < p_channels);
   assign accept  = rx_valid && !busy_q;

   // Bits above p_length in the final byte go out as zero
   always_comb begin
      snap_pad               = '0;
      snap_pad[p_length-1:0] = snap_q;
   end

   assign cur_byte  = err_q ? 8'hEE : snap_pad[{byte_q, 3'b000} +: 8];
   assign last_byte = err_q || (byte_q == c_last);

   always_comb begin
      t_state_d = t_state_q;
      t_timer_d = '0;
      byte_d    = byte_q;
      snap_d    = snap_q;
      err_d     = err_q;
      busy_d    = busy_q;
      cap_d     = 1'b0;
      tx_d      = 1'b1;
      d_idx     = '0;
      if (accept) begin
         busy_d = 1'b1;
         cap_d  = is_data;
         err_d  = !is_data;
         if (is_data) snap_d = chan_word;
      end
      if (t_state_q == T_IDLE) begin
         if (busy_q) t_state_d = T_START;
      end else begin
         t_timer_d = t_timer_q + 1'b1;
         if (t_timer_q == c_top_m1) begin
            t_timer_d = '0;
            if (t_state_q == T_STOP) begin
               if (last_byte) begin
                  t_state_d = T_IDLE;
                  busy_d    = 1'b0;
                  byte_d    = '0;
               end else begin
                  t_state_d = T_START;
                  byte_d    = byte_q + 1'b1;
               end
            end else begin
               t_state_d = t_state_e'(t_state_q + 4'd1);
            end
         end
      end
      // Line level is registered from the next state so it stays aligned with t_state_q
      unique case (t_state_d)
         T_IDLE:  tx_d = 1'b1;
         T_START: tx_d = 1'b0;
         T_STOP:  tx_d = 1'b1;
         default: begin
            d_idx = 3'(t_state_d - T_D0);
            tx_d  = cur_byte[d_idx];
         end
      endcase
   end

   assign uart.o_uart_tx = tx_q;
   assign uart.o_busy    = busy_q;
   assign uart.o_capture = cap_q;
endmodule

// File: tb/tb_x_uart_dump.sv
// tb/tb_x_uart_dump.sv - directed bench for the UART delay-line dumper
module tb_x_uart_dump;
   localparam int TA = 104;
   localparam int TB = 16;

   logic        clk;
   logic        a_nrst, b_nrst;
   logic [63:0] a_data;
   logic [11:0] b_data;
   int          total, bad;
   int          cyc;

   x_uart_dump_if ua ();
   x_uart_dump_if ub ();

   x_uart_dump #(.p_length(32), .p_channels(2), .p_clk_hz(12000000), .p_baud(115200)) dut_a (
      .i_clk(clk), .i_nrst(a_nrst), .i_data(a_data), .uart(ua));
   x_uart_dump #(.p_length(12), .p_channels(1), .p_clk_hz(1600), .p_baud(100)) dut_b (
      .i_clk(clk), .i_nrst(b_nrst), .i_data(b_data), .uart(ub));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int          qa[$], qb[$], sa[$], sb[$];
   int          a_stop_err, b_stop_err, a_caps, b_caps, a_busy_cnt;
   int          a_cap_cyc, a_rise_cyc, a_fall_cyc;
   logic        a_busy_prev;

   always @(negedge clk) begin
      if (ua.o_capture === 1'b1) begin a_caps++; a_cap_cyc = cyc; end
      if (ub.o_capture === 1'b1) b_caps++;
      if (ua.o_busy === 1'b1) a_busy_cnt++;
      if (ua.o_busy === 1'b1 && a_busy_prev === 1'b0) a_rise_cyc = cyc;
      if (ua.o_busy === 1'b0 && a_busy_prev === 1'b1) a_fall_cyc = cyc;
      a_busy_prev = ua.o_busy;
   end

   initial begin : mon_a
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (ua.o_uart_tx === 1'b0) begin
            sa.push_back(cyc);
            repeat (TA/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin repeat (TA) @(negedge clk); b[i] = ua.o_uart_tx; end
            repeat (TA) @(negedge clk);
            if (ua.o_uart_tx !== 1'b1) a_stop_err++;
            qa.push_back(int'(b));
         end
      end
   end

   initial begin : mon_b
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (ub.o_uart_tx === 1'b0) begin
            sb.push_back(cyc);
            repeat (TB/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin repeat (TB) @(negedge clk); b[i] = ub.o_uart_tx; end
            repeat (TB) @(negedge clk);
            if (ub.o_uart_tx !== 1'b1) b_stop_err++;
            qb.push_back(int'(b));
         end
      end
   end

   function automatic int qa_at(input int i); return (i < qa.size()) ? qa[i] : -1; endfunction
   function automatic int qb_at(input int i); return (i < qb.size()) ? qb[i] : -1; endfunction
   function automatic int sa_at(input int i); return (i < sa.size()) ? sa[i] : -1; endfunction
   function automatic int sb_at(input int i); return (i < sb.size()) ? sb[i] : -1; endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input bit to_b, input logic v);
      if (to_b) ub.i_uart_rx = v; else ua.i_uart_rx = v;
   endtask

   task automatic send(input bit to_b, input logic [7:0] v, input bit good_stop);
      int top;
      top = to_b ? TB : TA;
      set_rx(to_b, 1'b0);
      repeat (top) @(negedge clk);
      for (int i = 0; i < 8; i++) begin set_rx(to_b, v[i]); repeat (top) @(negedge clk); end
      if (good_stop) begin
         set_rx(to_b, 1'b1);
         repeat (top) @(negedge clk);
      end else begin
         set_rx(to_b, 1'b0);
         repeat (top*3/4) @(negedge clk);
         set_rx(to_b, 1'b1);
         repeat (top - top*3/4) @(negedge clk);
      end
   endtask

   task automatic wait_idle(input bit to_b, input string tag);
      int n;
      n = 0;
      while ((to_b ? ub.o_busy : ua.o_busy) !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
      check({tag, " idle_timeout"}, 32'(n < 20000), 32'd1);
   endtask

   task automatic check_word_a(input string tag, input int base, input logic [31:0] w);
      check({tag, " nbytes"}, 32'(qa.size() - base), 32'd4);
      for (int k = 0; k < 4; k++) check({tag, " byte"}, 32'(qa_at(base + k)), {24'd0, w[8*k +: 8]});
   endtask

   int base, sbase, c0, bc0, n0, target, n;

   initial begin
      total = 0; bad = 0; cyc = 0;
      a_stop_err = 0; b_stop_err = 0; a_caps = 0; b_caps = 0; a_busy_cnt = 0;
      a_cap_cyc = 0; a_rise_cyc = 0; a_fall_cyc = 0; a_busy_prev = 1'b0;
      a_nrst = 1'b0; b_nrst = 1'b0;
      ua.i_uart_rx = 1'b1; ub.i_uart_rx = 1'b1;
      a_data = '0; b_data = '0;
      repeat (3) @(negedge clk);
      check("reset tx", ua.o_uart_tx, 1);
      check("reset busy", ua.o_busy, 0);
      check("reset capture", ua.o_capture, 0);
      a_nrst = 1'b1; b_nrst = 1'b1;
      repeat (5) @(negedge clk);
      check("post-reset tx", ua.o_uart_tx, 1);

      // channel 1 dump
      a_data = {32'hA5C3_0F81, 32'h1234_5678};
      base = qa.size(); sbase = sa.size(); c0 = a_caps;
      send(0, 8'h01, 1);
      wait_idle(0, "ch1");
      repeat (10) @(negedge clk);
      check("ch1 captures", 32'(a_caps - c0), 1);
      check_word_a("ch1", base, 32'hA5C3_0F81);
      for (int k = 1; k < 4; k++) check("ch1 gap", 32'(sa_at(sbase + k) - sa_at(sbase + k - 1)), 32'd1040);
      check("ch1 start after capture", 32'(sa_at(sbase) - a_cap_cyc), 32'd1);
      check("ch1 stop bits", 32'(a_stop_err), 0);

      // out-of-range command -> 0xEE
      base = qa.size(); sbase = sa.size(); c0 = a_caps;
      send(0, 8'h05, 1);
      wait_idle(0, "err");
      repeat (10) @(negedge clk);
      check("err nbytes", 32'(qa.size() - base), 1);
      check("err byte", 32'(qa_at(base)), 32'hEE);
      check("err captures", 32'(a_caps - c0), 0);
      check("err busy rise->start", 32'(sa_at(sbase) - a_rise_cyc), 32'd1);
      check("err busy start->fall", 32'(a_fall_cyc - sa_at(sbase)), 32'd1040);

      // second command during reply, data changed mid-reply
      a_data = {32'h0, 32'hDEAD_BEEF};
      base = qa.size(); c0 = a_caps;
      send(0, 8'h00, 1);
      send(0, 8'h00, 1);
      check("overlap busy mid", ua.o_busy, 1);
      a_data = {32'h5555_5555, 32'h0BAD_F00D};
      wait_idle(0, "overlap");
      repeat (2000) @(negedge clk);
      check_word_a("overlap", base, 32'hDEAD_BEEF);
      check("overlap captures", 32'(a_caps - c0), 1);
      check("overlap busy after", ua.o_busy, 0);

      // framing error then a short glitch
      base = qa.size(); sbase = sa.size(); c0 = a_caps; n0 = a_busy_cnt;
      send(0, 8'h00, 0);
      repeat (200) @(negedge clk);
      ua.i_uart_rx = 1'b0;
      repeat (20) @(negedge clk);
      ua.i_uart_rx = 1'b1;
      repeat (1500) @(negedge clk);
      check("frame captures", 32'(a_caps - c0), 0);
      check("frame tx starts", 32'(sa.size() - sbase), 0);
      check("frame busy cycles", 32'(a_busy_cnt - n0), 0);
      a_data = {32'h0, 32'h1122_3344};
      send(0, 8'h00, 1);
      wait_idle(0, "after-frame");
      repeat (10) @(negedge clk);
      check_word_a("after-frame", base, 32'h1122_3344);
      check("after-frame captures", 32'(a_caps - c0), 1);

      // reset during T_D3 of the second byte
      a_data = {32'hCAFE_F00D, 32'h1122_3344};
      sbase = sa.size();
      send(0, 8'h01, 1);
      n = 0;
      while (sa.size() <= sbase && n < 5000) begin @(negedge clk); n++; end
      check("rst start seen", 32'(n < 5000), 1);
      target = sa_at(sbase) + 1040 + 4*TA + TA/2;
      n = 0;
      while (cyc < target && n < 5000) begin @(negedge clk); n++; end
      check("rst pre tx (F0 bit3)", ua.o_uart_tx, 0);
      check("rst pre busy", ua.o_busy, 1);
      a_nrst = 1'b0;
      #1;
      check("rst tx", ua.o_uart_tx, 1);
      check("rst busy", ua.o_busy, 0);
      repeat (3) @(negedge clk);
      a_nrst = 1'b1;
      repeat (1200) @(negedge clk);
      base = qa.size(); c0 = a_caps;
      send(0, 8'h00, 1);
      wait_idle(0, "post-rst");
      repeat (10) @(negedge clk);
      check_word_a("post-rst", base, 32'h1122_3344);
      check("post-rst captures", 32'(a_caps - c0), 1);

      // p_length=12, single channel
      b_data = 12'hABC;
      base = qb.size(); sbase = sb.size(); bc0 = b_caps;
      send(1, 8'h00, 1);
      wait_idle(1, "len12");
      repeat (10) @(negedge clk);
      check("len12 nbytes", 32'(qb.size() - base), 2);
      check("len12 byte0", 32'(qb_at(base)), 32'hBC);
      check("len12 byte1", 32'(qb_at(base + 1)), 32'h0A);
      check("len12 gap", 32'(sb_at(sbase + 1) - sb_at(sbase)), 32'd160);
      check("len12 captures", 32'(b_caps - bc0), 1);
      base = qb.size(); bc0 = b_caps;
      send(1, 8'h01, 1);
      wait_idle(1, "len12 err");
      repeat (10) @(negedge clk);
      check("len12 err byte", 32'(qb_at(base)), 32'hEE);
      check("len12 err captures", 32'(b_caps - bc0), 0);
      check("len12 stop bits", 32'(b_stop_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
